// File: rtl/mul_add_seq_pkg.sv
// Shared arithmetic-unit package: default widths and the IDLE/RUN state type
// used by the multiply-accumulator and the divider family.
package mul_add_seq_pkg;

    localparam int unsigned DEF_WQ = 32;
    localparam int unsigned DEF_WB = 16;
    localparam int unsigned DEF_WC = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_add_step.sv
// One shift-add step: acc + (bit_en ? q << idx : 0), evaluated at full result width.
module mul_add_step #(
    parameter int unsigned WQ = 32,
    parameter int unsigned WB = 16,
    parameter int unsigned WC = 4
) (
    input  logic [WQ+WB-1:0] acc,
    input  logic [WQ-1:0]    q,
    input  logic             bit_en,
    input  logic [WC-1:0]    idx,
    output logic [WQ+WB-1:0] sum_c
);

    localparam int unsigned WP = WQ + WB;

    logic [WP-1:0] addend;

    always_comb begin
        addend = '0;
        if (bit_en) begin
            addend = WP'(q) << idx;
        end
        sum_c = acc + addend;
    end

endmodule

// File: rtl/mul_add_seq.sv
// Sequential radix-2 shift-add multiply-accumulator, p = q*b + r, WB cycles per operation.
// Optional operand sanity flag chk_err enabled by defining MUL_ADD_SEQ_CHECK_EN.
module mul_add_seq
    import mul_add_seq_pkg::*;
#(
    parameter int unsigned WQ = DEF_WQ,
    parameter int unsigned WB = DEF_WB,
    parameter int unsigned WC = DEF_WC
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WQ-1:0]    q,
    input  logic [WB-1:0]    b,
    input  logic [WB-1:0]    r,
    input  logic             start,
    output logic [WQ+WB-1:0] p,
    output logic             busy,
    output logic             ready,
    output logic [WC-1:0]    count
`ifdef MUL_ADD_SEQ_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    localparam int unsigned WP = WQ + WB;
    localparam logic [WC-1:0] LAST = WC'(WB - 1);

    state_t        state, state_d;
    logic [WQ-1:0] q_r, q_d;
    logic [WB-1:0] b_r, b_d;
    logic [WP-1:0] acc, acc_d;
    logic [WP-1:0] p_d;
    logic [WP-1:0] sum_c;
    logic [WC-1:0] count_d;
    logic          busy_d, ready_d;

    mul_add_step #(
        .WQ (WQ),
        .WB (WB),
        .WC (WC)
    ) u_step (
        .acc    (acc),
        .q      (q_r),
        .bit_en (b_r[count]),
        .idx    (count),
        .sum_c  (sum_c)
    );

    // Next-state and next-output logic; ready defaults low so it is a single-cycle pulse.
    always_comb begin
        state_d = state;
        q_d     = q_r;
        b_d     = b_r;
        acc_d   = acc;
        p_d     = p;
        count_d = count;
        busy_d  = busy;
        ready_d = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    q_d     = q;
                    b_d     = b;
                    acc_d   = WP'(r);
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = sum_c;
                count_d = count + WC'(1);
                if (count == LAST) begin
                    p_d     = sum_c;
                    count_d = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            q_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            p     <= '0;
            count <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_d;
            q_r   <= q_d;
            b_r   <= b_d;
            acc   <= acc_d;
            p     <= p_d;
            count <= count_d;
            busy  <= busy_d;
            ready <= ready_d;
        end
    end

`ifdef MUL_ADD_SEQ_CHECK_EN
    // Operands that no divider could produce: zero divisor or remainder not below divisor.
    logic chk_pend;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            chk_pend <= 1'b0;
            chk_err  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                chk_pend <= (b == '0) || (r >= b);
            end
            if (ready_d) begin
                chk_err <= chk_pend;
            end
        end
    end
`endif

endmodule
